// File: rtl/pwm_rate_sequencer.sv
// Steps the PWM tick divider through up to four {pow2, pow5, dwell} rate profiles,
// resetting the divider on every rate change so it always restarts from a clean count.
module pwm_rate_sequencer #(
  parameter int DWELL_W = 12
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [DWELL_W+3:0] wr_data,
  input  logic [1:0]         last_idx,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  output logic [1:0]         pow2,
  output logic [1:0]         pow5,
  output logic               div_rstn,
  output logic               busy,
  output logic [1:0]         idx,
  output logic               step_pulse,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DWELL_W+3:0] tbl [4];
  logic [DWELL_W-1:0] tick_cnt, cnt_nxt;
  logic [DWELL_W-1:0] dwell_lim;
  logic [DWELL_W-1:0] load_dwell, load_lim;
  logic [1:0]         idx_nxt;
  logic               step_nxt, done_nxt;

  assign state_dbg = state;

  // Dwell is latched at load time so a live table write cannot move the terminal count.
  assign load_dwell = tbl[idx_nxt][DWELL_W+3:4];
  assign load_lim   = (load_dwell == '0) ? '0 : load_dwell - 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = tick_cnt;
    step_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt = S_LOAD;
          idx_nxt   = 2'd0;
        end
      end
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (tick_cnt == dwell_lim) begin
            step_nxt = 1'b1;
            cnt_nxt  = '0;
            if (idx != last_idx) begin
              idx_nxt   = idx + 2'd1;
              state_nxt = S_LOAD;
            end else if (loop_en) begin
              idx_nxt   = 2'd0;
              state_nxt = S_LOAD;
            end else begin
              done_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end
          end else begin
            cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pow2       <= 2'd0;
      pow5       <= 2'd0;
      div_rstn   <= 1'b0;
      busy       <= 1'b0;
      idx        <= 2'd0;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      tick_cnt   <= '0;
      dwell_lim  <= '0;
    end else begin
      div_rstn   <= (state_nxt == S_RUN);
      busy       <= (state_nxt != S_IDLE);
      idx        <= idx_nxt;
      step_pulse <= step_nxt;
      done       <= done_nxt;
      tick_cnt   <= cnt_nxt;
      if (state_nxt == S_LOAD) begin
        pow2      <= tbl[idx_nxt][1:0];
        pow5      <= tbl[idx_nxt][3:2];
        dwell_lim <= load_lim;
      end
    end
  end

endmodule

// File: tb/tb_pwm_rate_sequencer.sv
// Directed bench for pwm_rate_sequencer: bench-driven ticks plus a simple divider
// model for the looping case.
module tb_pwm_rate_sequencer;
  localparam int DWELL_W = 12;

  logic               clk = 1'b0;
  logic               rstn;
  logic               wr_en;
  logic [1:0]         wr_addr;
  logic [DWELL_W+3:0] wr_data;
  logic [1:0]         last_idx;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               tb_tick;
  logic               div_tick;
  logic               use_div;
  logic               tick;
  logic [1:0]         pow2, pow5, idx, state_dbg;
  logic               div_rstn, busy, step_pulse, done;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  assign tick = use_div ? div_tick : tb_tick;

  pwm_rate_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_idx(last_idx), .loop_en(loop_en), .start(start), .stop(stop), .tick(tick),
    .pow2(pow2), .pow5(pow5), .div_rstn(div_rstn), .busy(busy), .idx(idx),
    .step_pulse(step_pulse), .done(done), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Divider model: base period of 1000 clk at pow2=pow5=0, synchronous reset.
  int div_cnt;
  int div_lim;
  always_comb begin
    div_lim = 1000 * (1 << pow2);
    for (int k = 0; k < 3; k++) if (k < int'(pow5)) div_lim = div_lim * 5;
  end
  always_ff @(posedge clk) begin
    if (!div_rstn) begin
      div_cnt  <= 0;
      div_tick <= 1'b0;
    end else if (div_cnt == div_lim - 1) begin
      div_cnt  <= 0;
      div_tick <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1;
      div_tick <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input int dwell, input int p5, input int p2);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {dwell[DWELL_W-1:0], p5[1:0], p2[1:0]};
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_tick();
    tb_tick = 1'b1;
    cyc();
    tb_tick = 1'b0;
  endtask

  task automatic start_seq();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_idx = '0;
    loop_en = 1'b0; start = 1'b0; stop = 1'b0; tb_tick = 1'b0; use_div = 1'b0;
    #1;
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    check_val("rst_pow2", pow2, 0);
    check_val("rst_pow5", pow5, 0);
    check_val("rst_div_rstn", div_rstn, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_idx", idx, 0);
    check_val("rst_step_done", {step_pulse, done}, 0);
    tb_tick = 1'b1;
    repeat (3) cyc();
    tb_tick = 1'b0;
    check_val("idle_tick_busy", busy, 0);
    check_val("idle_tick_state", state_dbg, 0);

    // Two-entry non-looping run
    write_entry(2'd0, 3, 0, 0);
    write_entry(2'd1, 2, 1, 2);
    last_idx = 2'd1; loop_en = 1'b0;
    start_seq();
    check_val("load_state", state_dbg, 1);
    check_val("load_div_rstn", div_rstn, 0);
    check_val("load_busy", busy, 1);
    check_val("load_pow", {pow5, pow2}, 0);
    cyc();
    check_val("run_state", state_dbg, 2);
    check_val("run_div_rstn", div_rstn, 1);
    pulse_tick(); cyc();
    pulse_tick();
    check_val("two_tick_no_step", step_pulse, 0);
    pulse_tick();
    check_val("e0_step", step_pulse, 1);
    check_val("e1_load_state", state_dbg, 1);
    check_val("e1_pow2", pow2, 2);
    check_val("e1_pow5", pow5, 1);
    check_val("e1_idx", idx, 1);
    cyc();
    check_val("e1_step_clear", step_pulse, 0);
    pulse_tick();
    check_val("e1_mid_done", done, 0);
    pulse_tick();
    check_val("seq_done", done, 1);
    check_val("seq_idle", state_dbg, 0);
    check_val("seq_div_rstn", div_rstn, 0);
    check_val("seq_idx_hold", idx, 1);
    cyc();
    check_val("done_one_cycle", done, 0);

    // Stop beats a dwell-completing tick
    write_entry(2'd0, 1, 0, 1);
    last_idx = 2'd0;
    start_seq(); cyc();
    tb_tick = 1'b1; stop = 1'b1;
    cyc();
    tb_tick = 1'b0; stop = 1'b0;
    check_val("stop_state", state_dbg, 0);
    check_val("stop_step_done", {step_pulse, done}, 0);
    check_val("stop_busy", busy, 0);
    check_val("stop_div_rstn", div_rstn, 0);
    check_val("stop_pow2_hold", pow2, 1);

    // Dwell of zero behaves as one
    write_entry(2'd0, 0, 0, 3);
    start_seq(); cyc();
    pulse_tick();
    check_val("dwell0_step", step_pulse, 1);
    check_val("dwell0_done", done, 1);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    check_val("start_stop_idle", state_dbg, 0);
    check_val("start_stop_busy", busy, 0);

    // start held while busy
    write_entry(2'd0, 2, 0, 0);
    write_entry(2'd1, 1, 0, 1);
    last_idx = 2'd1;
    start = 1'b1;
    cyc(); cyc();
    pulse_tick();
    check_val("busy_start_idx", idx, 0);
    check_val("busy_start_nostep", step_pulse, 0);
    pulse_tick();
    start = 1'b0;
    check_val("busy_start_step", step_pulse, 1);
    check_val("busy_start_idx1", idx, 1);
    cyc();
    pulse_tick();
    check_val("busy_start_done", done, 1);

    // Live write to the active entry
    write_entry(2'd0, 2, 0, 0);
    last_idx = 2'd0; loop_en = 1'b1;
    start_seq(); cyc();
    write_entry(2'd0, 2, 0, 3);
    check_val("live_pow2_hold", pow2, 0);
    pulse_tick();
    check_val("live_pow2_hold2", pow2, 0);
    pulse_tick();
    check_val("live_reload_step", step_pulse, 1);
    check_val("live_reload_pow2", pow2, 3);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Looping with the divider model
    begin
      int cyc_n, last_step, steps, lows;
      logic done_seen;
      write_entry(2'd0, 2, 0, 0);
      use_div = 1'b1;
      repeat (3) exp_q.push_back(32'd2002);
      cyc_n = 0; last_step = -1; steps = 0; lows = 0; done_seen = 1'b0;
      start_seq();
      while (steps < 4 && cyc_n < 9000) begin
        cyc();
        cyc_n++;
        if (done) done_seen = 1'b1;
        if (!div_rstn) lows++;
        if (step_pulse) begin
          if (last_step >= 0 && exp_q.size() > 0) begin
            check_val("loop_period", cyc_n - last_step, exp_q.pop_front());
            check_val("loop_div_rst_cycles", lows, 1);
          end
          last_step = cyc_n;
          lows = 0;
          steps++;
        end
      end
      check_val("loop_steps_seen", steps, 4);
      check_val("loop_no_done", done_seen, 0);
      stop = 1'b1; cyc(); stop = 1'b0;
      use_div = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
